// File: rtl/hdmi_pkg.sv
// Shared TMDS constants: control tokens, guard-band words, TERC4 table, mode encodings.
package hdmi_pkg;

    localparam logic [1:0] MODE_CTL   = 2'b00;
    localparam logic [1:0] MODE_VID   = 2'b01;
    localparam logic [1:0] MODE_GB    = 2'b10;
    localparam logic [1:0] MODE_TERC4 = 2'b11;

    // All words below are in standard TMDS order (bit 0 first on the wire).
    localparam logic [9:0] TMDS_CTL0 = 10'h354;
    localparam logic [9:0] TMDS_CTL1 = 10'h0ab;
    localparam logic [9:0] TMDS_CTL2 = 10'h154;
    localparam logic [9:0] TMDS_CTL3 = 10'h2ab;

    localparam logic [9:0] TMDS_GB_VID0 = 10'h2cc;
    localparam logic [9:0] TMDS_GB_VID1 = 10'h133;
    localparam logic [9:0] TMDS_GB_VID2 = 10'h2cc;

    // Indexed by the TERC4 nibble; entry 15 is the leftmost element.
    localparam logic [15:0][9:0] TMDS_TERC4 = {
        10'h2c3, 10'h163, 10'h271, 10'h28e, 10'h2c6, 10'h19c, 10'h139, 10'h2cc,
        10'h13c, 10'h18e, 10'h11e, 10'h171, 10'h2e2, 10'h2e4, 10'h263, 10'h29c
    };

    function automatic logic [9:0] bit_reverse10(input logic [9:0] w);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) begin
            r[i] = w[9-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/tmds_qm.sv
// Transition-minimising first half of TMDS 8b/10b: data byte -> q_m[8:0] and its ones count.
module tmds_qm (
    input  logic [7:0] i_data,
    output logic [8:0] o_qm,
    output logic [3:0] o_n1q
);

    logic [3:0] n1d;
    logic       use_xnor;

    // XNOR chain when the byte is ones-heavy, XOR chain otherwise; bit 8 flags which.
    always_comb begin
        n1d = '0;
        for (int i = 0; i < 8; i++) begin
            n1d = n1d + {3'b000, i_data[i]};
        end
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !i_data[0]);
        o_qm = '0;
        o_qm[0] = i_data[0];
        for (int i = 1; i < 8; i++) begin
            o_qm[i] = use_xnor ? ~(o_qm[i-1] ^ i_data[i]) : (o_qm[i-1] ^ i_data[i]);
        end
        o_qm[8] = ~use_xnor;
        o_n1q = '0;
        for (int i = 0; i < 8; i++) begin
            o_n1q = o_n1q + {3'b000, o_qm[i]};
        end
    end

endmodule

// File: rtl/hdmi_tmds_encoder.sv
// Transmit-side TMDS channel encoder: control, video, guard band and TERC4, 2-clock latency.
module hdmi_tmds_encoder
    import hdmi_pkg::*;
#(
    parameter int unsigned CHANNEL        = 0,
    parameter bit          OPT_BITREVERSE = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_mode,
    input  logic [1:0] i_ctl,
    input  logic [7:0] i_data,
    input  logic [3:0] i_aux,
    output logic [9:0] o_word,
    output logic [4:0] o_disparity
);

    localparam logic [9:0] GB_WORD = (CHANNEL == 1) ? TMDS_GB_VID1 :
                                     (CHANNEL == 2) ? TMDS_GB_VID2 : TMDS_GB_VID0;

    logic [8:0] qm;
    logic [3:0] n1q;

    logic [1:0] mode_q;
    logic [1:0] ctl_q;
    logic [3:0] aux_q;
    logic [8:0] qm_q;
    logic [3:0] n1q_q;

    logic [9:0]        word_d, word_q;
    logic signed [4:0] cnt_d, cnt_q;
    logic [4:0]        twice_n1;
    logic signed [4:0] diff;
    logic signed [4:0] two_if_qm8;

    tmds_qm u_qm (
        .i_data (i_data),
        .o_qm   (qm),
        .o_n1q  (n1q)
    );

    // Stage 1: capture mode/side data and the transition-minimised byte.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mode_q <= MODE_CTL;
            ctl_q  <= 2'b00;
            aux_q  <= '0;
            qm_q   <= '0;
            n1q_q  <= '0;
        end else begin
            mode_q <= i_mode;
            ctl_q  <= i_ctl;
            aux_q  <= i_aux;
            qm_q   <= qm;
            n1q_q  <= n1q;
        end
    end

    // Stage 2: pick the output word and advance the running disparity.
    always_comb begin
        twice_n1   = {n1q_q, 1'b0};
        diff       = $signed(twice_n1 - 5'd8);   // n1q - n0q; modular, result fits in 5 bits
        two_if_qm8 = qm_q[8] ? 5'sd2 : 5'sd0;
        word_d     = TMDS_CTL0;
        cnt_d      = '0;
        unique case (mode_q)
            MODE_VID: begin
                if ((cnt_q == 5'sd0) || (n1q_q == 4'd4)) begin
                    word_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
                    cnt_d  = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
                end else if (((cnt_q > 5'sd0) && (n1q_q > 4'd4)) ||
                             ((cnt_q < 5'sd0) && (n1q_q < 4'd4))) begin
                    word_d = {1'b1, qm_q[8], ~qm_q[7:0]};
                    cnt_d  = cnt_q + two_if_qm8 - diff;
                end else begin
                    word_d = {1'b0, qm_q[8], qm_q[7:0]};
                    cnt_d  = cnt_q - (5'sd2 - two_if_qm8) + diff;
                end
            end
            MODE_GB:    word_d = GB_WORD;
            MODE_TERC4: word_d = TMDS_TERC4[aux_q];
            default: begin
                unique case (ctl_q)
                    2'b01:   word_d = TMDS_CTL1;
                    2'b10:   word_d = TMDS_CTL2;
                    2'b11:   word_d = TMDS_CTL3;
                    default: word_d = TMDS_CTL0;
                endcase
            end
        endcase
    end

    // Output register; bit order for the serializer is fixed here only.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            word_q <= OPT_BITREVERSE ? bit_reverse10(TMDS_CTL0) : TMDS_CTL0;
            cnt_q  <= '0;
        end else begin
            word_q <= OPT_BITREVERSE ? bit_reverse10(word_d) : word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_word      = word_q;
    assign o_disparity = cnt_q;

endmodule

// File: tb/tb_hdmi_tmds_encoder.sv
// Self-checking bench: two encoder builds against a behavioural TMDS reference model.
module tb_hdmi_tmds_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [1:0] ctl;
    logic [7:0] data;
    logic [3:0] aux;
    logic [9:0] word_a, word_b;
    logic [4:0] disp_a, disp_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [9:0] w;
        int         disp;
    } entry_t;

    entry_t pend_a[$];
    entry_t pend_b[$];
    int     cnt_a = 0;
    int     cnt_b = 0;

    logic [9:0] terc_tab[16] = '{
        10'h29c, 10'h263, 10'h2e4, 10'h2e2, 10'h171, 10'h11e, 10'h18e, 10'h13c,
        10'h2cc, 10'h139, 10'h19c, 10'h2c6, 10'h28e, 10'h271, 10'h163, 10'h2c3
    };
    logic [9:0] ctl_tab[4] = '{10'h354, 10'h0ab, 10'h154, 10'h2ab};

    always #5 clk = ~clk;

    // Build A: channel 0, bit-reversed output.  Build B: channel 1, standard order.
    hdmi_tmds_encoder #(.CHANNEL(0), .OPT_BITREVERSE(1'b1)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_mode(mode), .i_ctl(ctl), .i_data(data), .i_aux(aux),
        .o_word(word_a), .o_disparity(disp_a)
    );
    hdmi_tmds_encoder #(.CHANNEL(1), .OPT_BITREVERSE(1'b0)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_mode(mode), .i_ctl(ctl), .i_data(data), .i_aux(aux),
        .o_word(word_b), .o_disparity(disp_b)
    );

    function automatic logic [9:0] rev10(input logic [9:0] w);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = w[9-i];
        return r;
    endfunction

    // Reference encoder for one input word, standard order, integer running disparity.
    task automatic model(input logic [1:0] m, input logic [1:0] c, input logic [7:0] d,
                         input logic [3:0] a, input int ch, input int cnt_in,
                         output logic [9:0] w, output int cnt_out);
        int         n1d, n1q, n0q;
        bit         use_xnor;
        logic [8:0] q;
        cnt_out = 0;
        case (m)
            2'b00: w = ctl_tab[c];
            2'b10: w = (ch == 1) ? 10'h133 : 10'h2cc;
            2'b11: w = terc_tab[a];
            default: begin
                n1d = $countones(d);
                use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
                q[0] = d[0];
                for (int i = 1; i < 8; i++)
                    q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
                q[8] = !use_xnor;
                n1q = $countones(q[7:0]);
                n0q = 8 - n1q;
                if (cnt_in == 0 || n1q == 4) begin
                    w = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
                    cnt_out = cnt_in + (q[8] ? (n1q - n0q) : (n0q - n1q));
                end else if ((cnt_in > 0 && n1q > 4) || (cnt_in < 0 && n1q < 4)) begin
                    w = {1'b1, q[8], ~q[7:0]};
                    cnt_out = cnt_in + 2 * int'(q[8]) + (n0q - n1q);
                end else begin
                    w = {1'b0, q[8], q[7:0]};
                    cnt_out = cnt_in - 2 * int'(!q[8]) + (n1q - n0q);
                end
            end
        endcase
    endtask

    task automatic check_eq(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, let both builds and the model advance, compare outputs.
    task automatic step(input logic [1:0] m, input logic [1:0] c, input logic [7:0] d,
                        input logic [3:0] a, input logic r);
        entry_t     ea, eb, na, nb;
        logic [9:0] w;
        int         nc;
        mode = m; ctl = c; data = d; aux = a; rst = r;
        @(posedge clk);
        #1;
        if (r) begin
            pend_a.delete();
            pend_b.delete();
            cnt_a = 0;
            cnt_b = 0;
            ea = '{w: 10'h354, disp: 0};
            eb = ea;
            pend_a.push_back(ea);
            pend_b.push_back(eb);
        end else begin
            model(m, c, d, a, 0, cnt_a, w, nc);
            cnt_a = nc;
            na = '{w: w, disp: nc};
            model(m, c, d, a, 1, cnt_b, w, nc);
            cnt_b = nc;
            nb = '{w: w, disp: nc};
            pend_a.push_back(na);
            pend_b.push_back(nb);
            ea = pend_a.pop_front();
            eb = pend_b.pop_front();
        end
        check_eq("word_a", word_a, rev10(ea.w));
        check_eq("disp_a", {5'b0, disp_a}, {5'b0, 5'(ea.disp)});
        check_eq("word_b", word_b, eb.w);
        check_eq("disp_b", {5'b0, disp_b}, {5'b0, 5'(eb.disp)});
    endtask

    int          sd;
    logic [1:0]  rm;

    initial begin
        rst = 1'b1; mode = 2'b00; ctl = 2'b01; data = '0; aux = '0;

        // Reset held 4 clocks with ctl=01 presented, then release.
        for (int i = 0; i < 4; i++) step(2'b00, 2'b01, 8'h00, 4'h0, 1'b1);
        for (int i = 0; i < 4; i++) step(2'b00, 2'b01, 8'h00, 4'h0, 1'b0);

        // All-zero pixels from a balanced start.
        for (int i = 0; i < 4; i++) step(2'b01, 2'b00, 8'h00, 4'h0, 1'b0);
        // Two fixed words for the first zero pixels, independent of the model.
        step(2'b00, 2'b00, 8'h00, 4'h0, 1'b0);
        step(2'b01, 2'b00, 8'h00, 4'h0, 1'b0);
        step(2'b01, 2'b00, 8'h00, 4'h0, 1'b0);
        check_eq("zero_px_first", word_b, 10'h100);
        step(2'b01, 2'b00, 8'h00, 4'h0, 1'b0);
        check_eq("zero_px_second", word_b, 10'h3ff);

        // Long random video run with a disparity bound on both builds.
        for (int i = 0; i < 10000; i++) begin
            step(2'b01, 2'b00, 8'($urandom), 4'h0, 1'b0);
            sd = int'($signed(disp_a));
            checks++;
            assert ((sd <= 10) && (sd >= -10) && (sd % 2 == 0)) else begin
                failures++;
                $error("FAIL disp_bound observed=%0d expected=even_within_10", sd);
            end
        end

        // Control, guard band, video, then back to control.
        for (int i = 0; i < 8; i++) step(2'b00, 2'(i), 8'h00, 4'h0, 1'b0);
        for (int i = 0; i < 2; i++) step(2'b10, 2'b00, 8'h00, 4'h0, 1'b0);
        for (int i = 0; i < 16; i++) step(2'b01, 2'b00, 8'($urandom), 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) step(2'b00, 2'b11, 8'h00, 4'h0, 1'b0);

        // TERC4 sweep of all nibbles.
        for (int i = 0; i < 16; i++) step(2'b11, 2'b00, 8'h00, 4'(i), 1'b0);
        for (int i = 0; i < 2; i++) step(2'b00, 2'b00, 8'h00, 4'h0, 1'b0);

        // Reset pulse inside a video run.
        for (int i = 0; i < 8; i++) step(2'b01, 2'b00, 8'($urandom), 4'h0, 1'b0);
        step(2'b01, 2'b00, 8'($urandom), 4'h0, 1'b1);
        for (int i = 0; i < 8; i++) step(2'b01, 2'b00, 8'($urandom), 4'h0, 1'b0);

        // Random mode mix with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rm = 2'($urandom);
            step(rm, 2'($urandom), 8'($urandom), 4'($urandom), ($urandom_range(0, 49) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
